wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
Writeback arbiter and scoreboard sitting directly upstream of the 32x32 register file write port. It merges two result sources into the single write port: the in-order pipeline writeback (W stage) and the out-of-order multiply/divide unit. It drives the register file's write-enable, write-address and write-data inputs, and buffers multdiv results in a small FIFO when the W stage holds the port. It also keeps a 32-bit pending-write scoreboard so the decode stage can stall on RAW and WAW hazards against in-flight multdiv results.

Parameters:
DEPTH, 2, multdiv result FIFO entries; power of two, at least 2.

Ports:
clock  input  1  system clock, rising edge.
ctrl_reset_n  input  1  asynchronous active-low reset.
wb_valid  input  1  W stage has a result this cycle (single-cycle, no backpressure).
wb_rd  input  5  W stage destination register.
wb_data  input  32  W stage result.
md_issue  input  1  multdiv operation issued this cycle.
md_issue_rd  input  5  destination register of the issued multdiv operation.
md_valid  input  1  multdiv result offered.
md_rd  input  5  multdiv result destination register.
md_data  input  32  multdiv result.
md_ready  output  1  result accepted when md_valid and md_ready are both high.
chk_rs1, chk_rs2, chk_rd  input  5 each  decode-stage register indices to check.
stall  output  1  high if any checked index is pending.
pending  output  32  scoreboard vector; bit 0 is always 0.
ctrl_writeEnable  output  1  to regfile.
ctrl_writeReg  output  5  to regfile.
data_writeReg  output  32  to regfile.

Behaviour:
- Reset (asynchronous, ctrl_reset_n low): FIFO flushed (count=0, pointers=0); pending=0; md_ready=1. Write outputs are combinational from the flushed state, so ctrl_writeEnable=0 unless wb_valid is high with a nonzero wb_rd. Reset asserted mid-operation drops all buffered results with no write.
- Effective W write: wb_valid && wb_rd!=0. wb_valid with wb_rd=0 does not use the port.
- Port arbitration (combinational, zero latency), in priority order:
  1) Effective W write: port driven from the wb_* inputs.
  2) Otherwise, if the FIFO is non-empty: port driven from the FIFO head, and the head pops at the clock edge.
  3) Otherwise, if md_valid && md_rd!=0 (FIFO empty): cut-through; port driven from md_*, nothing is enqueued.
  4) Otherwise: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
- md_ready = (count < DEPTH). It is registered-state based only and does not depend on md_valid.
- Accepted md result with md_rd=0: discarded (no write, no enqueue).
- Accepted md result that is not cut through: enqueued at the tail. A push and a pop in the same cycle leave count unchanged.
- FIFO wrap-around: pointers are log2(DEPTH) bits and wrap naturally; count has range 0..DEPTH.
- Full FIFO: md_ready=0 and md_valid is ignored. The multdiv unit must hold its result until md_ready is high.
- Scoreboard:
  - Set pending[md_issue_rd] at the clock edge when md_issue && md_issue_rd!=0.
  - Clear pending[r] at the clock edge when the port writes a multdiv-sourced result to r (pop or cut-through).
  - Set and clear of the same bit in the same cycle: set wins.
- stall = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd]. Combinational from the registered vector.
- Precondition, enforced by stall: the W stage never writes a register whose pending bit is set, and md_issue never targets a pending register. A bench assertion flags wb_valid with pending[wb_rd]=1.
- Results write in acceptance order; there is no reordering within the FIFO.

Test Plan:
- Reset then idle: ctrl_reset_n low mid-run with 2 entries buffered -> pending=0, md_ready=1, ctrl_writeEnable=0, and no later write of the flushed entries.
- Cut-through: md_issue rd=5; later md_valid rd=5 data=0xDEADBEEF with wb_valid=0 and FIFO empty -> same-cycle write of r5=0xDEADBEEF; pending[5] clears at that edge; stall with chk_rs1=5 drops the next cycle.
- Collision and buffering: wb_valid rd=3 data=0x11 in the same cycle as md_valid rd=7 data=0x22 -> cycle N writes r3=0x11; cycle N+1 (wb_valid=0) writes r7=0x22 from the FIFO.
- Full FIFO: wb_valid held high with nonzero rd for 4 cycles while md offers 3 results -> first 2 accepted, md_ready=0 on the third; when wb drops, drains in order, then the third is accepted.
- r0 handling: wb_valid rd=0 while the FIFO holds rd=9 -> r9 is written that cycle. md_valid rd=0 -> accepted, no write, count unchanged. md_issue rd=0 -> pending stays 0.
- Set/clear race: md_issue rd=4 in the same cycle a buffered rd=4 result pops -> r4 is written and pending[4] remains 1.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: W-stage and multdiv result inputs, decode hazard
// checks, and the register file write port.
interface wb_arbiter_if;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        stall;
    logic [31:0] pending;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;

    modport master (
        output wb_valid, wb_rd, wb_data, md_issue, md_issue_rd,
               md_valid, md_rd, md_data, chk_rs1, chk_rs2, chk_rd,
        input  md_ready, stall, pending, ctrl_writeEnable, ctrl_writeReg, data_writeReg
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, md_issue, md_issue_rd,
               md_valid, md_rd, md_data, chk_rs1, chk_rs2, chk_rd,
        output md_ready, stall, pending, ctrl_writeEnable, ctrl_writeReg, data_writeReg
    );
endinterface

// File: rtl/wb_arbiter.sv
// Merges W-stage and multdiv results onto the single register file write port,
// buffering multdiv results and tracking in-flight multdiv destinations.
module wb_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input logic         clock,
    input logic         ctrl_reset_n,
    wb_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [4:0]    rdMem   [DEPTH];
    logic [31:0]   dataMem [DEPTH];
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [CW-1:0] count;
    logic [31:0]   pendingQ;
    logic [31:0]   pendingNext;

    logic          mdReady;
    logic          wbWrite;
    logic          fifoEmpty;
    logic          popHead;
    logic          cutThrough;
    logic          pushTail;
    logic          mdWrite;
    logic [4:0]    clearRd;
    logic [4:0]    headRd;
    logic [31:0]   headData;

    assign mdReady  = (count < CW'(DEPTH));
    assign headRd   = rdMem[headPtr];
    assign headData = dataMem[headPtr];

    // Port priority: W stage, then FIFO head, then multdiv cut-through.
    always_comb begin
        wbWrite    = bus.wb_valid && (bus.wb_rd != 5'd0);
        fifoEmpty  = (count == '0);
        popHead    = !wbWrite && !fifoEmpty;
        cutThrough = !wbWrite && fifoEmpty && bus.md_valid && (bus.md_rd != 5'd0);
        pushTail   = bus.md_valid && mdReady && (bus.md_rd != 5'd0) && !cutThrough;
        mdWrite    = popHead || cutThrough;
        clearRd    = popHead ? headRd : bus.md_rd;

        bus.ctrl_writeEnable = 1'b0;
        bus.ctrl_writeReg    = '0;
        bus.data_writeReg    = '0;
        if (wbWrite) begin
            bus.ctrl_writeEnable = 1'b1;
            bus.ctrl_writeReg    = bus.wb_rd;
            bus.data_writeReg    = bus.wb_data;
        end else if (popHead) begin
            bus.ctrl_writeEnable = 1'b1;
            bus.ctrl_writeReg    = headRd;
            bus.data_writeReg    = headData;
        end else if (cutThrough) begin
            bus.ctrl_writeEnable = 1'b1;
            bus.ctrl_writeReg    = bus.md_rd;
            bus.data_writeReg    = bus.md_data;
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_comb begin
        pendingNext = pendingQ;
        if (mdWrite) begin
            pendingNext[clearRd] = 1'b0;
        end
        if (bus.md_issue && (bus.md_issue_rd != 5'd0)) begin
            pendingNext[bus.md_issue_rd] = 1'b1;
        end
        pendingNext[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (pushTail) begin
            rdMem[tailPtr]   <= bus.md_rd;
            dataMem[tailPtr] <= bus.md_data;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            count    <= '0;
            pendingQ <= '0;
        end else begin
            if (popHead) begin
                headPtr <= headPtr + PW'(1);
            end
            if (pushTail) begin
                tailPtr <= tailPtr + PW'(1);
            end
            case ({pushTail, popHead})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            pendingQ <= pendingNext;
        end
    end

    assign bus.md_ready = mdReady;
    assign bus.pending  = pendingQ;
    assign bus.stall    = pendingQ[bus.chk_rs1] | pendingQ[bus.chk_rs2] | pendingQ[bus.chk_rd];
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_wb_arbiter;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    wb_arbiter_if bus();
    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clock        (clk),
        .ctrl_reset_n (rstN),
        .bus          (bus.slave)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;

    res_t        mq[$];
    logic [31:0] mPend;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic        expWe;
    logic [4:0]  expReg;
    logic [31:0] expData;
    logic        expReady;
    logic        expStall;
    logic        expFromMd;

    // bench-side multdiv unit
    logic [4:0]  inflight[$];
    logic        holding = 1'b0;
    logic [4:0]  holdRd;
    logic [31:0] holdData;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void predict();
        expReady  = (mq.size() < DEPTH);
        expWe     = 1'b0;
        expReg    = '0;
        expData   = '0;
        expFromMd = 1'b0;
        if (bus.wb_valid && bus.wb_rd != 5'd0) begin
            expWe = 1'b1; expReg = bus.wb_rd; expData = bus.wb_data;
        end else if (mq.size() > 0) begin
            expWe = 1'b1; expReg = mq[0].rd; expData = mq[0].data; expFromMd = 1'b1;
        end else if (bus.md_valid && bus.md_rd != 5'd0) begin
            expWe = 1'b1; expReg = bus.md_rd; expData = bus.md_data; expFromMd = 1'b1;
        end
        expStall = mPend[bus.chk_rs1] | mPend[bus.chk_rs2] | mPend[bus.chk_rd];
    endfunction

    task automatic compareAll();
        predict();
        chk("writeEnable", 32'(bus.ctrl_writeEnable), 32'(expWe));
        chk("writeReg", 32'(bus.ctrl_writeReg), 32'(expReg));
        chk("writeData", bus.data_writeReg, expData);
        chk("md_ready", 32'(bus.md_ready), 32'(expReady));
        chk("pending", bus.pending, mPend);
        chk("stall", 32'(bus.stall), 32'(expStall));
        if (bus.wb_valid && bus.wb_rd != 5'd0)
            chk("wb_hazard", 32'(bus.pending[bus.wb_rd]), 32'd0);
    endtask

    task automatic modelFlush();
        mq.delete();
        mPend = '0;
    endtask

    task automatic advance();
        logic popped;
        logic cut;
        if (!rstN) begin
            modelFlush();
            return;
        end
        predict();
        popped = expFromMd && (mq.size() > 0);
        cut    = expFromMd && (mq.size() == 0);
        if (popped) void'(mq.pop_front());
        if (bus.md_valid && expReady && bus.md_rd != 5'd0 && !cut)
            mq.push_back('{rd: bus.md_rd, data: bus.md_data});
        if (expFromMd) mPend[expReg] = 1'b0;
        if (bus.md_issue && bus.md_issue_rd != 5'd0) mPend[bus.md_issue_rd] = 1'b1;
    endtask

    task automatic settle();
        #1;
        compareAll();
    endtask

    task automatic tick();
        advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        bus.md_issue = 1'b0; bus.md_issue_rd = '0;
        bus.md_valid = 1'b0; bus.md_rd = '0; bus.md_data = '0;
        bus.chk_rs1 = '0; bus.chk_rs2 = '0; bus.chk_rd = '0;
    endtask

    task automatic issueOnly(input logic [4:0] rd);
        idle();
        bus.md_issue = 1'b1; bus.md_issue_rd = rd;
        settle();
        tick();
    endtask

    task automatic setWb(input logic [4:0] rd, input logic [31:0] d);
        bus.wb_valid = 1'b1; bus.wb_rd = rd; bus.wb_data = d;
    endtask

    task automatic setMd(input logic [4:0] rd, input logic [31:0] d);
        bus.md_valid = 1'b1; bus.md_rd = rd; bus.md_data = d;
    endtask

    task automatic expectWrite(input string name, input logic [4:0] rd, input logic [31:0] d);
        chk({name, "_we"}, 32'(bus.ctrl_writeEnable), 32'd1);
        chk({name, "_reg"}, 32'(bus.ctrl_writeReg), 32'(rd));
        chk({name, "_data"}, bus.data_writeReg, d);
    endtask

    task automatic randomCycle(input bit enWb, input bit enIssue);
        int unsigned idx;
        logic [4:0]  r;
        idle();
        if (!holding && inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
            idx = $urandom_range(0, inflight.size() - 1);
            holdRd = inflight[idx];
            inflight.delete(idx);
            holdData = $urandom;
            holding = 1'b1;
        end else if (!holding && enIssue && $urandom_range(0, 19) == 0) begin
            holdRd = '0;
            holdData = $urandom;
            holding = 1'b1;
        end
        if (holding) setMd(holdRd, holdData);
        if (enWb && $urandom_range(0, 1) == 1) begin
            r = 5'($urandom_range(0, 31));
            if (mPend[r]) r = '0;
            setWb(r, $urandom);
        end
        if (enIssue && $urandom_range(0, 2) == 0) begin
            r = 5'($urandom_range(0, 31));
            if (!mPend[r]) begin
                bus.md_issue = 1'b1;
                bus.md_issue_rd = r;
                if (r != 5'd0) inflight.push_back(r);
            end
        end
        bus.chk_rs1 = 5'($urandom_range(0, 31));
        bus.chk_rs2 = 5'($urandom_range(0, 31));
        bus.chk_rd  = 5'($urandom_range(0, 31));
        settle();
        if (holding && expReady) holding = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rstN = 1'b0;
        modelFlush();
        @(posedge clk);
        #1;
        settle();
        chk("rst_pending", bus.pending, 32'd0);
        chk("rst_ready", 32'(bus.md_ready), 32'd1);
        chk("rst_we", 32'(bus.ctrl_writeEnable), 32'd0);
        tick();
        rstN = 1'b1;
        idle(); settle(); tick();

        // cut-through
        issueOnly(5'd5);
        idle(); bus.chk_rs1 = 5'd5; settle();
        chk("ct_pend", bus.pending, 32'h0000_0020);
        chk("ct_stall_hi", 32'(bus.stall), 32'd1);
        tick();
        idle(); bus.chk_rs1 = 5'd5; setMd(5'd5, 32'hDEAD_BEEF); settle();
        expectWrite("ct", 5'd5, 32'hDEAD_BEEF);
        tick();
        idle(); bus.chk_rs1 = 5'd5; settle();
        chk("ct_stall_lo", 32'(bus.stall), 32'd0);
        chk("ct_pend_clr", bus.pending, 32'd0);
        tick();

        // collision: W wins, multdiv result buffered
        issueOnly(5'd7);
        idle(); setWb(5'd3, 32'h11); setMd(5'd7, 32'h22); settle();
        expectWrite("col_n", 5'd3, 32'h11);
        tick();
        idle(); settle();
        expectWrite("col_n1", 5'd7, 32'h22);
        tick();

        // full FIFO
        issueOnly(5'd10); issueOnly(5'd11); issueOnly(5'd12);
        idle(); setWb(5'd1, 32'hA1); setMd(5'd10, 32'h100); settle(); tick();
        idle(); setWb(5'd2, 32'hA2); setMd(5'd11, 32'h101); settle(); tick();
        idle(); setWb(5'd3, 32'hA3); setMd(5'd12, 32'h102); settle();
        chk("full_ready0", 32'(bus.md_ready), 32'd0);
        tick();
        idle(); setWb(5'd4, 32'hA4); setMd(5'd12, 32'h102); settle(); tick();
        idle(); setMd(5'd12, 32'h102); settle();
        expectWrite("full_d0", 5'd10, 32'h100);
        chk("full_ready_d0", 32'(bus.md_ready), 32'd0);
        tick();
        idle(); setMd(5'd12, 32'h102); settle();
        expectWrite("full_d1", 5'd11, 32'h101);
        chk("full_ready_d1", 32'(bus.md_ready), 32'd1);
        tick();
        idle(); settle();
        expectWrite("full_d2", 5'd12, 32'h102);
        tick();

        // r0 handling
        issueOnly(5'd9);
        idle(); setWb(5'd2, 32'h5); setMd(5'd9, 32'h99); settle(); tick();
        idle(); setWb(5'd0, 32'h555); settle();
        expectWrite("r0_wb", 5'd9, 32'h99);
        tick();
        idle(); setMd(5'd0, 32'h77); settle();
        chk("r0_md_we", 32'(bus.ctrl_writeEnable), 32'd0);
        tick();
        idle(); settle();
        chk("r0_md_ready", 32'(bus.md_ready), 32'd1);
        tick();
        issueOnly(5'd0);
        idle(); settle();
        chk("r0_issue_pend", bus.pending, 32'd0);
        tick();

        // set/clear race
        issueOnly(5'd4);
        idle(); setWb(5'd6, 32'h6); setMd(5'd4, 32'h44); settle(); tick();
        idle(); bus.md_issue = 1'b1; bus.md_issue_rd = 5'd4; settle();
        expectWrite("race", 5'd4, 32'h44);
        tick();
        idle(); settle();
        chk("race_pend", bus.pending, 32'h0000_0010);
        tick();
        idle(); setMd(5'd4, 32'h45); settle();
        expectWrite("race_ct", 5'd4, 32'h45);
        tick();

        // reset with two buffered entries
        issueOnly(5'd13); issueOnly(5'd14);
        idle(); setWb(5'd1, 32'h1); setMd(5'd13, 32'h13); settle(); tick();
        idle(); setWb(5'd2, 32'h2); setMd(5'd14, 32'h14); settle();
        chk("mid_ready0", 32'(bus.md_ready), 32'd1);
        tick();
        idle(); rstN = 1'b0; modelFlush(); settle();
        chk("mid_rst_pend", bus.pending, 32'd0);
        chk("mid_rst_ready", 32'(bus.md_ready), 32'd1);
        chk("mid_rst_we", 32'(bus.ctrl_writeEnable), 32'd0);
        tick();
        rstN = 1'b1;
        idle(); settle();
        chk("post_rst_we0", 32'(bus.ctrl_writeEnable), 32'd0);
        tick();
        idle(); settle();
        chk("post_rst_we1", 32'(bus.ctrl_writeEnable), 32'd0);
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) randomCycle(1'b1, 1'b1);
        for (int c = 0; c < 300 && (inflight.size() > 0 || holding || mq.size() > 0); c++)
            randomCycle(1'b1, 1'b0);
        idle(); settle();
        chk("drain_pending", bus.pending, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
